// File: rtl/mdu_iterative_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// M-extension funct3 values, FSM states and operand-signedness decode.
package mdu_iterative_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // Returns {a_is_signed, b_is_signed} for a given funct3.
  function automatic logic [1:0] operand_signs(input logic [2:0] f3);
    logic [1:0] signs;
    case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: signs = 2'b11;
      F3_MULHSU:                       signs = 2'b10;
      default:                         signs = 2'b00;
    endcase
    return signs;
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_iterative_if #(
  parameter int N = 32
);
  logic         start;
  logic [2:0]   funct3;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         flush;
  logic [N-1:0] result;
  logic         busy;
  logic         done;
  logic         stall_req;

  modport master (
    output start, funct3, A, B, flush,
    input  result, busy, done, stall_req
  );

  modport slave (
    input  start, funct3, A, B, flush,
    output result, busy, done, stall_req
  );
endinterface

// File: rtl/mdu_iterative_nbit_addsub.sv
// W-bit adder/subtractor with carry-out; shared by the multiply accumulate
// and the restoring-division trial subtract (cout=1 means a >= b on subtract).
module mdu_iterative_nbit_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff_s;
  logic [W:0]   total_s;

  // Two's-complement add of a and optionally inverted b
  always_comb begin
    b_eff_s = b ^ {W{sub}};
    total_s = {1'b0, a} + {1'b0, b_eff_s} + {{W{1'b0}}, sub};
  end

  assign sum  = total_s[W-1:0];
  assign cout = total_s[W];

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add / restoring
// shift-subtract over N cycles, then one sign-fix cycle and a done pulse.
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int N = 32
) (
  input logic            clk,
  input logic            rst,
  mdu_iterative_if.slave bus
);

  localparam int              CW       = $clog2(N) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0]   ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]    ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0]  ONE_2N   = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]    MIN_N    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]    ONES_N   = {N{1'b1}};
  localparam logic [N-1:0]    ZERO_N   = {N{1'b0}};

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
    return ~v + ONE_N;
  endfunction

  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
    return ~v + ONE_2N;
  endfunction

  mdu_state_e      state_r;
  logic [2:0]      f3_r;
  logic [N-1:0]    ua_r;
  logic [N-1:0]    ub_r;
  logic [N-1:0]    a_r;
  logic            neg_res_r;
  logic            neg_rem_r;
  logic            dz_r;
  logic            ovf_r;
  logic [2*N-1:0]  prod_r;
  logic [N-1:0]    rem_r;
  logic [N-1:0]    quo_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    result_r;
  logic            busy_r;
  logic            done_r;

  logic [1:0]      signs_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [N-1:0]    abs_a_s;
  logic [N-1:0]    abs_b_s;
  logic            ovf_s;
  logic [N:0]      shifted_s;
  logic [N:0]      add_a_s;
  logic [N:0]      add_b_s;
  logic            add_sub_s;
  logic [N:0]      add_sum_s;
  logic            add_cout_s;
  logic [2*N-1:0]  prod_fix_s;
  logic [N-1:0]    quo_fix_s;
  logic [N-1:0]    rem_fix_s;
  logic [N-1:0]    sel_s;

  // Operand magnitudes and special-case flags for an incoming request
  always_comb begin
    signs_s = operand_signs(bus.funct3);
    a_neg_s = signs_s[1] & bus.A[N-1];
    b_neg_s = signs_s[0] & bus.B[N-1];
    if (a_neg_s) begin
      abs_a_s = neg_n(bus.A);
    end else begin
      abs_a_s = bus.A;
    end
    if (b_neg_s) begin
      abs_b_s = neg_n(bus.B);
    end else begin
      abs_b_s = bus.B;
    end
    ovf_s = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
            (bus.A == MIN_N) && (bus.B == ONES_N);
  end

  // Shared adder operands: accumulate for multiply, trial subtract for divide
  always_comb begin
    shifted_s = {1'b0, rem_r, quo_r[N-1]};
    shifted_s = shifted_s[N:0];
    if (f3_r[2]) begin
      add_a_s   = shifted_s;
      add_b_s   = {1'b0, ub_r};
      add_sub_s = 1'b1;
    end else begin
      add_a_s   = {1'b0, prod_r[2*N-1:N]};
      add_sub_s = 1'b0;
      if (prod_r[0]) begin
        add_b_s = {1'b0, ua_r};
      end else begin
        add_b_s = {(N+1){1'b0}};
      end
    end
  end

  mdu_iterative_nbit_addsub #(
    .W(N + 1)
  ) u_addsub (
    .a    (add_a_s),
    .b    (add_b_s),
    .sub  (add_sub_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Sign correction of the magnitude results
  always_comb begin
    if (neg_res_r) begin
      prod_fix_s = neg_2n(prod_r);
      quo_fix_s  = neg_n(quo_r);
    end else begin
      prod_fix_s = prod_r;
      quo_fix_s  = quo_r;
    end
    if (neg_rem_r) begin
      rem_fix_s = neg_n(rem_r);
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // Final result selection, with divide-by-zero and overflow overrides
  always_comb begin
    case (f3_r)
      F3_MUL:                       sel_s = prod_fix_s[N-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: sel_s = prod_fix_s[2*N-1:N];
      F3_DIV, F3_DIVU: begin
        if (dz_r) begin
          sel_s = ONES_N;
        end else if (ovf_r) begin
          sel_s = a_r;
        end else begin
          sel_s = quo_fix_s;
        end
      end
      F3_REM, F3_REMU: begin
        if (dz_r) begin
          sel_s = a_r;
        end else if (ovf_r) begin
          sel_s = ZERO_N;
        end else begin
          sel_s = rem_fix_s;
        end
      end
      default: sel_s = ZERO_N;
    endcase
  end

  // Control FSM with the iterative datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      f3_r      <= 3'b000;
      ua_r      <= ZERO_N;
      ub_r      <= ZERO_N;
      a_r       <= ZERO_N;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      ovf_r     <= 1'b0;
      prod_r    <= {(2*N){1'b0}};
      rem_r     <= ZERO_N;
      quo_r     <= ZERO_N;
      cnt_r     <= {CW{1'b0}};
      result_r  <= ZERO_N;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && !bus.flush) begin
            f3_r      <= bus.funct3;
            ua_r      <= abs_a_s;
            ub_r      <= abs_b_s;
            a_r       <= bus.A;
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            dz_r      <= (bus.B == ZERO_N);
            ovf_r     <= ovf_s;
            prod_r    <= {ZERO_N, abs_b_s};
            rem_r     <= ZERO_N;
            quo_r     <= abs_a_s;
            cnt_r     <= {CW{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= ST_CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            if (f3_r[2]) begin
              // Restore on borrow: keep the shifted remainder, quotient bit 0
              if (add_cout_s) begin
                rem_r <= add_sum_s[N-1:0];
                quo_r <= {quo_r[N-2:0], 1'b1};
              end else begin
                rem_r <= shifted_s[N-1:0];
                quo_r <= {quo_r[N-2:0], 1'b0};
              end
            end else begin
              prod_r <= {add_sum_s, prod_r[N-1:1]};
            end
            cnt_r <= cnt_r + ONE_CNT;
            if (cnt_r == LAST_CNT) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_FIX: begin
          if (bus.flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            result_r <= sel_s;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.result    = result_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.stall_req = ((state_r == ST_IDLE) & bus.start & ~bus.flush) | busy_r;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: a cycle-timeline reference model checked
// every cycle, plus hand-computed results and latencies for each scenario.
module tb_mdu_iterative;

  localparam int N   = 32;
  localparam int LAT = N + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  int          m_acc    = -1;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_exp    = 32'h0;

  mdu_iterative_if #(.N(N)) bus ();

  mdu_iterative #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit m_idle(input int c);
    return (m_acc < 0) || (c > m_acc + LAT);
  endfunction

  // Architectural RV32M result, computed with plain 64-bit/int arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    int sa;
    int sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b000, 3'b001: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; end
      3'b010:         begin ea = {{32{a[31]}}, a}; eb = {32'h0, b}; end
      default:        begin ea = {32'h0, a};       eb = {32'h0, b}; end
    endcase
    p = ea * eb;
    case (f3)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return sa / sb;
      end
      3'b101:  return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        return sa % sb;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Timeline model: accept, result update, flush abort and reset at each edge
  always @(posedge clk) begin
    if (rst) begin
      m_acc    <= -1;
      m_result <= 32'h0;
    end else begin
      if (m_acc >= 0 && cyc == m_acc + LAT - 1 && !bus.flush)
        m_result <= m_exp;
      if (m_acc >= 0 && bus.flush && cyc > m_acc && cyc <= m_acc + LAT) begin
        m_acc <= -1;
      end else if (m_idle(cyc) && bus.start && !bus.flush) begin
        m_acc <= cyc;
        m_exp <= ref_mdu(bus.funct3, bus.A, bus.B);
      end
    end
    cyc <= cyc + 1;
  end

  // Per-cycle comparison against the model
  initial begin
    logic busy_e;
    logic done_e;
    logic stall_e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        busy_e  = (m_acc >= 0) && (cyc > m_acc) && (cyc < m_acc + LAT);
        done_e  = (m_acc >= 0) && (cyc == m_acc + LAT);
        stall_e = busy_e | (m_idle(cyc) & bus.start & ~bus.flush);
        check("busy",      {31'h0, bus.busy},      {31'h0, busy_e});
        check("done",      {31'h0, bus.done},      {31'h0, done_e});
        check("stall_req", {31'h0, bus.stall_req}, {31'h0, stall_e});
        check("result",    bus.result,             m_result);
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
    int s;
    int lat;
    bit seen;
    bus.funct3 = f3;
    bus.A      = a;
    bus.B      = b;
    bus.start  = 1'b1;
    s          = cyc;
    @(negedge clk);
    check({nm, "_stall0"}, {31'h0, bus.stall_req}, 32'h1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat  = cyc - s;
      end
    end
    check({nm, "_latency"}, lat, LAT);
    check(nm, bus.result, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int ndone;
    int dlat;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.A      = 32'h0;
    bus.B      = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_result", bus.result, 32'h0);
    check("rst_busy",   {31'h0, bus.busy}, 32'h0);
    check("rst_done",   {31'h0, bus.done}, 32'h0);
    @(posedge clk);
    #1;

    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, "rem");
    run_op(3'b101, 32'd100,        32'd7,          32'd14,        "divu");
    run_op(3'b111, 32'd100,        32'd7,          32'd2,         "remu");
    run_op(3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, "divu_by0");
    run_op(3'b110, 32'd5,          32'd0,          32'd5,         "rem_by0");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, "div_neg_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf");

    // start together with flush in IDLE must be dropped
    bus.funct3 = 3'b000;
    bus.A      = 32'd2;
    bus.B      = 32'd3;
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", {31'h0, bus.busy}, 32'h0);
    @(posedge clk);
    #1;

    // starts during an operation are ignored
    s          = cyc;
    bus.funct3 = 3'b000;
    bus.A      = 32'd3;
    bus.B      = 32'd5;
    bus.start  = 1'b1;
    ndone      = 0;
    dlat       = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      bus.start = (k == 5 || k == 20);
      bus.A     = 32'd9;
      bus.B     = 32'd11;
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        dlat = cyc - s;
      end
    end
    bus.start = 1'b0;
    check("ignore_ndone",  ndone, 32'd1);
    check("ignore_lat",    dlat, LAT);
    check("ignore_result", bus.result, 32'd15);
    @(posedge clk);
    #1;

    // flush mid-CALC: no done, result unchanged
    s          = cyc;
    bus.funct3 = 3'b101;
    bus.A      = 32'd100;
    bus.B      = 32'd7;
    bus.start  = 1'b1;
    ndone      = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = (k == 10);
      @(negedge clk);
      if (k == 11) check("flush_busy", {31'h0, bus.busy}, 32'h0);
      if (bus.done) ndone++;
    end
    bus.flush = 1'b0;
    check("flush_ndone",  ndone, 32'd0);
    check("flush_result", bus.result, 32'd15);
    @(posedge clk);
    #1;

    // reset mid-operation, then a fresh start two cycles later
    s          = cyc;
    bus.funct3 = 3'b000;
    bus.A      = 32'd6;
    bus.B      = 32'd7;
    bus.start  = 1'b1;
    ndone      = 0;
    dlat       = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      rst       = (k == 10);
      bus.start = (k == 12);
      if (k == 12) begin
        bus.funct3 = 3'b011;
        bus.A      = 32'hFFFF_FFFF;
        bus.B      = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      if (k == 11) begin
        check("rstmid_result", bus.result, 32'h0);
        check("rstmid_busy",   {31'h0, bus.busy}, 32'h0);
      end
      if (bus.done) begin
        ndone++;
        dlat = cyc - s;
      end
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    check("rstmid_ndone",  ndone, 32'd1);
    check("rstmid_lat",    dlat, 32'd46);
    check("rstmid_result2", bus.result, 32'hFFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Takes rs1/rs2 operands and funct3 from the ID/EX register and computes one result over N+2 cycles.
- Holds the pipeline through stall_req while it works.
- Its result is the M-extension input to the EX result-select mux that feeds EX/MEM.

Parameters:
- N, 32, operand/result width in bits (even, ≥4).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  in  N  rs1 operand (multiplicand/dividend).
- B  in  N  rs2 operand (multiplier/divisor).
- flush  in  1  abort current operation (branch/exception flush).
- result  out  N  final value; valid when done=1, held until next accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- stall_req  out  1  combinational: (state==IDLE & start & ~flush) | busy.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - result=0, busy=0, done=0.
  - All internal registers cleared.
  - Overrides start/flush; applies mid-operation too.
- FSM states are IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1 & flush=0: latch funct3.
  - Latch |A|,|B| per signedness: signed for MUL/MULH/DIV/REM; A signed, B unsigned for MULHSU; unsigned otherwise.
  - Latch result sign flags; clear count; go to CALC.
- CALC: exactly N cycles, one iteration per cycle.
  - Multiply: shift-add on a 2N-bit product register (LSB-first multiplier).
  - Divide: restoring shift-subtract; quotient and N+1-bit partial remainder registers.
- FIX: one cycle.
  - Apply two's-complement sign correction.
  - Product negated if signs differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Select the low or high N bits, or the quotient/remainder, into result.
- DONE: done=1 for exactly this cycle, then IDLE. busy=0 in DONE and IDLE; busy=1 in CALC and FIX.
- Latency: start sampled at edge t → done=1 during cycle t+N+2; fixed for all funct3 and operand values.
- Width rule: MUL returns product[N-1:0]; MULH* return product[2N-1:N]; every path is computed at 2N bits, with no truncation before selection.
- Divide by zero (B=0), decided in FIX regardless of iteration outcome:
  - DIV/DIVU → all ones.
  - REM/REMU → A.
- Signed overflow (A=-2^(N-1), B=-1):
  - DIV → A.
  - REM → 0.
- start while busy or in DONE: ignored, never queued.
- flush=1 in CALC/FIX/DONE:
  - Next state IDLE; busy=0 next cycle.
  - No done pulse; result keeps its previous value.
- flush=1 in IDLE with start=1: start is ignored.
- result updates only in FIX; it is stable at all other times.

Decomposition:
- Shared defines include (alongside the existing opcode defines): M-extension funct3 encodings MUL..REMU, and the FSM state encodings.
- One natural sub-module, nbit_addsub: N+1-bit add/subtract with carry-out. It serves both the shift-add accumulate and the restoring trial subtract.
- Final result selection uses the existing NbitMUX chain.

Test Plan:
1. MUL with A=7, B=0xFFFFFFFD; start at cycle 0 → done at cycle 34, result=0xFFFFFFEB; stall_req high cycles 0–33, low at 34.
2. MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
4. DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0; latency still 34.
5. start pulsed at cycles 5 and 20 during an op begun at 0 → single done at 34, result from first op only.
6. flush at cycle 10 → busy=0 at 11, no done through cycle 40, result unchanged. rst at cycle 10 → result=0, IDLE; a new start at 12 gives done at 46.
